// File: rtl/RV32i_pkg.sv
// Shared RV32I encodings, select codes and the pipelined control bundle type.
package RV32i_pkg;

  localparam logic [2:0] SEL_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] SEL_PC_BRANCH = 3'd1;
  localparam logic [2:0] SEL_PC_JAL    = 3'd2;
  localparam logic [2:0] SEL_PC_JALR   = 3'd3;

  localparam logic [1:0] SEL_OP1_RS1  = 2'd0;
  localparam logic [1:0] SEL_OP1_PC   = 2'd1;
  localparam logic [1:0] SEL_OP1_ZERO = 2'd2;

  localparam logic SEL_OP2_RS2 = 1'b0;
  localparam logic SEL_OP2_IMM = 1'b1;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SEL_WB_ALU       = 2'd0;
  localparam logic [1:0] SEL_WB_MEM       = 2'd1;
  localparam logic [1:0] SEL_WB_PC_PLUS_4 = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] alu_src1;
    logic       alu_src2;
    logic [2:0] imm_gen_sel;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       mem_we;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
  } ctrl_t;

  // All-zero bundle doubles as the NOP: ALU ADD, write-back ALU, no side effects.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv32i_decoder.sv
// Pure combinational RV32I instruction to control-bundle decoder.
module rv32i_decoder
  import RV32i_pkg::*;
(
  input  logic [31:0] instruction_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       alt;
  logic [3:0] alu_func;
  ctrl_t      ctrl;
  logic       unused_bits;

  assign opcode      = instruction_i[6:0];
  assign func3       = instruction_i[14:12];
  assign alt         = instruction_i[30];
  assign unused_bits = ^{instruction_i[31], instruction_i[29:25]};

  always_comb begin
    unique case (func3)
      3'b000:  alu_func = ALU_ADD;
      3'b001:  alu_func = ALU_SLL;
      3'b010:  alu_func = ALU_SLT;
      3'b011:  alu_func = ALU_SLTU;
      3'b100:  alu_func = ALU_XOR;
      3'b101:  alu_func = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_func = ALU_OR;
      default: alu_func = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl       = CTRL_NOP;
    ctrl.rd    = instruction_i[11:7];
    ctrl.rs1   = instruction_i[19:15];
    ctrl.rs2   = instruction_i[24:20];
    ctrl.func3 = func3;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_control = (func3 == 3'b000 && alt) ? ALU_SUB : alu_func;
        ctrl.reg_we      = 1'b1;
        ctrl.use_rs1     = 1'b1;
        ctrl.use_rs2     = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_control = alu_func;
        ctrl.alu_src2    = SEL_OP2_IMM;
        ctrl.imm_gen_sel = IMM_I;
        ctrl.reg_we      = 1'b1;
        ctrl.use_rs1     = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_src2    = SEL_OP2_IMM;
        ctrl.imm_gen_sel = IMM_I;
        ctrl.wb_sel      = SEL_WB_MEM;
        ctrl.reg_we      = 1'b1;
        ctrl.use_rs1     = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src2    = SEL_OP2_IMM;
        ctrl.imm_gen_sel = IMM_S;
        ctrl.mem_we      = 1'b1;
        ctrl.use_rs1     = 1'b1;
        ctrl.use_rs2     = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_control = (func3[2:1] == 2'b00) ? ALU_SUB :
                           (func3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
        ctrl.imm_gen_sel = IMM_B;
        ctrl.branch      = 1'b1;
        ctrl.use_rs1     = 1'b1;
        ctrl.use_rs2     = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_gen_sel = IMM_J;
        ctrl.wb_sel      = SEL_WB_PC_PLUS_4;
        ctrl.reg_we      = 1'b1;
        ctrl.jump        = 1'b1;
      end
      OPC_JALR: begin
        ctrl.imm_gen_sel = IMM_I;
        ctrl.wb_sel      = SEL_WB_PC_PLUS_4;
        ctrl.reg_we      = 1'b1;
        ctrl.jalr        = 1'b1;
        ctrl.use_rs1     = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alu_src1    = SEL_OP1_ZERO;
        ctrl.alu_src2    = SEL_OP2_IMM;
        ctrl.imm_gen_sel = IMM_U;
        ctrl.reg_we      = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_src1    = SEL_OP1_PC;
        ctrl.alu_src2    = SEL_OP2_IMM;
        ctrl.imm_gen_sel = IMM_U;
        ctrl.reg_we      = 1'b1;
      end
      default: ;
    endcase
    // x0 is never written, which also keeps it out of hazard detection.
    if (ctrl.rd == 5'd0) ctrl.reg_we = 1'b0;
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/rv32i_pipeline_controlpath.sv
// Control path for a 4-stage (D/E/M/W) RV32I pipeline: decode, stall-on-hazard, redirects.
module rv32i_pipeline_controlpath
  import RV32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [31:0] instruction_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  output logic        stall_o,
  output logic        fetch_nop_o,
  output logic        dec_nop_o,
  output logic [2:0]  pc_next_sel_o,
  output logic [2:0]  imm_gen_sel_o,
  output logic [1:0]  alu_src1_o,
  output logic        alu_src2_o,
  output logic [3:0]  alu_control_o,
  output logic        dmem_we_o,
  output logic        reg_we_o,
  output logic [4:0]  rd_add_o,
  output logic [1:0]  wb_sel_o
);

  ctrl_t dec;
  ctrl_t e_q, m_q, w_q;
  ctrl_t e_d;
  logic  hazard;
  logic  branch_taken;
  logic  unused_ctrl;

  rv32i_decoder u_decoder (
    .instruction_i (instruction_i),
    .ctrl_o        (dec)
  );

  function automatic logic writes_reg(input ctrl_t c, input logic [4:0] r);
    return c.reg_we && (c.rd == r);
  endfunction

  // No bypass network: any pending write to a source register blocks decode.
  always_comb begin
    hazard = 1'b0;
    if (dec.use_rs1 && dec.rs1 != 5'd0 &&
        (writes_reg(e_q, dec.rs1) || writes_reg(m_q, dec.rs1) || writes_reg(w_q, dec.rs1))) begin
      hazard = 1'b1;
    end
    if (dec.use_rs2 && dec.rs2 != 5'd0 &&
        (writes_reg(e_q, dec.rs2) || writes_reg(m_q, dec.rs2) || writes_reg(w_q, dec.rs2))) begin
      hazard = 1'b1;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    if (e_q.branch) begin
      case (e_q.func3)
        3'b000:  branch_taken = alu_zero_i;
        3'b001:  branch_taken = !alu_zero_i;
        3'b100,
        3'b110:  branch_taken = alu_lt_i;
        3'b101,
        3'b111:  branch_taken = !alu_lt_i;
        default: branch_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_next_sel_o = SEL_PC_PLUS_4;
    stall_o       = 1'b0;
    fetch_nop_o   = 1'b0;
    dec_nop_o     = 1'b0;
    if (branch_taken) begin
      pc_next_sel_o = SEL_PC_BRANCH;
      fetch_nop_o   = 1'b1;
      dec_nop_o     = 1'b1;
    end else if (hazard) begin
      stall_o   = 1'b1;
      dec_nop_o = 1'b1;
    end else if (dec.jump) begin
      pc_next_sel_o = SEL_PC_JAL;
      fetch_nop_o   = 1'b1;
    end else if (dec.jalr) begin
      pc_next_sel_o = SEL_PC_JALR;
      fetch_nop_o   = 1'b1;
    end
  end

  assign e_d = dec_nop_o ? CTRL_NOP : dec;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      e_q <= CTRL_NOP;
      m_q <= CTRL_NOP;
      w_q <= CTRL_NOP;
    end else begin
      e_q <= e_d;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  assign imm_gen_sel_o = dec.imm_gen_sel;
  assign alu_src1_o    = dec.alu_src1;
  assign alu_src2_o    = dec.alu_src2;
  assign alu_control_o = e_q.alu_control;
  assign dmem_we_o     = m_q.mem_we;
  assign reg_we_o      = w_q.reg_we;
  assign rd_add_o      = w_q.rd;
  assign wb_sel_o      = w_q.wb_sel;

  assign unused_ctrl = ^{e_q, m_q, w_q};

endmodule

// File: tb/tb_rv32i_pipeline_controlpath.sv
// Directed self-checking bench for rv32i_pipeline_controlpath.
module tb_rv32i_pipeline_controlpath;
  import RV32i_pkg::*;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        alu_lt;
  logic        stall, fetch_nop, dec_nop, alu_src2, dmem_we, reg_we;
  logic [2:0]  pc_next_sel, imm_gen_sel;
  logic [1:0]  alu_src1, wb_sel;
  logic [3:0]  alu_control;
  logic [4:0]  rd_add;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] ADD2 = 32'h0010_8133;
  localparam logic [31:0] JAL  = 32'h0080_00EF;
  localparam logic [31:0] JALR = 32'h0000_80E7;
  localparam logic [31:0] BEQ  = 32'h0000_0863;
  localparam logic [31:0] LW   = 32'h0000_2183;
  localparam logic [31:0] SW   = 32'h0030_2223;
  localparam logic [31:0] ADD0 = 32'h0000_0033;

  always #5 clk_i = ~clk_i;

  rv32i_pipeline_controlpath dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .instruction_i (instruction),
    .alu_zero_i    (alu_zero),
    .alu_lt_i      (alu_lt),
    .stall_o       (stall),
    .fetch_nop_o   (fetch_nop),
    .dec_nop_o     (dec_nop),
    .pc_next_sel_o (pc_next_sel),
    .imm_gen_sel_o (imm_gen_sel),
    .alu_src1_o    (alu_src1),
    .alu_src2_o    (alu_src2),
    .alu_control_o (alu_control),
    .dmem_we_o     (dmem_we),
    .reg_we_o      (reg_we),
    .rd_add_o      (rd_add),
    .wb_sel_o      (wb_sel)
  );

  // One pipeline cycle: new D instruction after the edge, outputs sampled at negedge.
  task automatic drive(input logic [31:0] ins, input logic z, input logic lt);
    @(posedge clk_i);
    #1;
    instruction = ins;
    alu_zero    = z;
    alu_lt      = lt;
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn_i    = 1'b0;
    instruction = NOP;
    alu_zero    = 1'b0;
    alu_lt      = 1'b0;

    // Reset
    repeat (3) drive(NOP, 1'b0, 1'b0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pc_sel", 32'(pc_next_sel), 32'(SEL_PC_PLUS_4));
    chk("rst_rd", 32'(rd_add), 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'(SEL_WB_ALU));
    chk("rst_alu", 32'(alu_control), 32'(ALU_ADD));
    resetn_i = 1'b1;

    // RAW hazard: three stall cycles, writer visible in W on the third
    drive(ADDI, 1'b0, 1'b0);
    chk("haz_addi_nostall", 32'(stall), 32'd0);
    drive(ADD2, 1'b0, 1'b0);
    chk("haz_stall1", 32'({stall, dec_nop}), 32'b11);
    drive(ADD2, 1'b0, 1'b0);
    chk("haz_stall2", 32'({stall, dec_nop}), 32'b11);
    drive(ADD2, 1'b0, 1'b0);
    chk("haz_stall3", 32'({stall, dec_nop}), 32'b11);
    chk("haz_w_we_rd", 32'({reg_we, rd_add}), 32'({1'b1, 5'd1}));
    drive(ADD2, 1'b0, 1'b0);
    chk("haz_release", 32'({stall, dec_nop}), 32'b00);
    repeat (3) drive(NOP, 1'b0, 1'b0);

    // JAL
    drive(JAL, 1'b0, 1'b0);
    chk("jal_redirect", 32'({pc_next_sel, fetch_nop, stall}), 32'({SEL_PC_JAL, 1'b1, 1'b0}));
    chk("jal_imm_sel", 32'(imm_gen_sel), 32'(IMM_J));
    drive(NOP, 1'b0, 1'b0);
    chk("jal_one_cycle", 32'({pc_next_sel, fetch_nop}), 32'({SEL_PC_PLUS_4, 1'b0}));
    drive(NOP, 1'b0, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    chk("jal_wb", 32'({reg_we, rd_add, wb_sel}), 32'({1'b1, 5'd1, SEL_WB_PC_PLUS_4}));

    // Taken then not-taken BEQ
    drive(BEQ, 1'b0, 1'b0);
    chk("beq_in_d", 32'(pc_next_sel), 32'(SEL_PC_PLUS_4));
    drive(NOP, 1'b1, 1'b0);
    chk("beq_taken", 32'({pc_next_sel, fetch_nop, dec_nop}), 32'({SEL_PC_BRANCH, 2'b11}));
    chk("beq_alu_sub", 32'(alu_control), 32'(ALU_SUB));
    drive(NOP, 1'b1, 1'b0);
    chk("beq_one_cycle", 32'({pc_next_sel, fetch_nop, dec_nop}), 32'({SEL_PC_PLUS_4, 2'b00}));
    drive(BEQ, 1'b0, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    chk("beq_not_taken", 32'({pc_next_sel, fetch_nop, dec_nop}), 32'({SEL_PC_PLUS_4, 2'b00}));

    // Load / store
    drive(LW, 1'b0, 1'b0);
    chk("lw_imm_src2", 32'({imm_gen_sel, alu_src2}), 32'({IMM_I, SEL_OP2_IMM}));
    repeat (3) drive(NOP, 1'b0, 1'b0);
    chk("lw_wb", 32'({wb_sel, reg_we, rd_add}), 32'({SEL_WB_MEM, 1'b1, 5'd3}));
    drive(SW, 1'b0, 1'b0);
    chk("sw_no_stall", 32'(stall), 32'd0);
    chk("sw_imm", 32'(imm_gen_sel), 32'(IMM_S));
    drive(NOP, 1'b0, 1'b0);
    chk("sw_dmem_early", 32'(dmem_we), 32'd0);
    drive(NOP, 1'b0, 1'b0);
    chk("sw_dmem_we", 32'(dmem_we), 32'd1);
    drive(NOP, 1'b0, 1'b0);
    chk("sw_no_reg_we", 32'({reg_we, dmem_we}), 32'b00);

    // x0 reads never stall
    drive(NOP, 1'b0, 1'b0);
    drive(ADD0, 1'b0, 1'b0);
    chk("x0_no_stall", 32'({stall, dec_nop}), 32'b00);
    repeat (3) drive(NOP, 1'b0, 1'b0);

    // Hazard while a taken branch sits in E: branch wins
    drive(ADDI, 1'b0, 1'b0);
    drive(BEQ, 1'b0, 1'b0);
    drive(ADD2, 1'b1, 1'b0);
    chk("br_over_haz", 32'({stall, pc_next_sel, dec_nop}), 32'({1'b0, SEL_PC_BRANCH, 1'b1}));
    drive(ADD2, 1'b0, 1'b0);
    chk("haz_after_br", 32'(stall), 32'd1);
    repeat (3) drive(NOP, 1'b0, 1'b0);

    // Mid-flight reset discards the pending writer
    drive(ADDI, 1'b0, 1'b0);
    drive(ADD2, 1'b0, 1'b0);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    resetn_i = 1'b0;
    #1;
    chk("mid_rst_clear", 32'({stall, reg_we, dmem_we}), 32'b000);
    @(negedge clk_i);
    resetn_i = 1'b1;
    drive(ADD2, 1'b0, 1'b0);
    chk("post_rst_stall", 32'(stall), 32'd0);

    // JALR redirect
    drive(JALR, 1'b0, 1'b0);
    chk("jalr_redirect", 32'({pc_next_sel, fetch_nop}), 32'({SEL_PC_JALR, 1'b1}));
    drive(NOP, 1'b0, 1'b0);
    chk("jalr_one_cycle", 32'(pc_next_sel), 32'(SEL_PC_PLUS_4));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
